readback_uart_tx: RTL
=====================

Name: readback_uart_tx

Overview:
Serial transmitter for the host link; the return path of the UART command receiver. It accepts one register-readback record per handshake: a 12-bit shape address, a 12-bit register address and 12-bit data. It serialises the record as a fixed 7-byte packet, 8N1, LSB first, on a single TX line. It sits beside the input path and is driven by the render core's readback/acknowledge logic.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
HEADER_BYTE, 8'hA5, sync byte sent first in every packet.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low.
tx_valid  input  1  record request; held until accepted.
tx_ready  output  1  high when a record can be accepted.
shape_addr  input  12  shape index, sampled on accept.
reg_addr  input  12  register index, sampled on accept.
data_in  input  12  register value, sampled on accept.
serial_output  output  1  UART TX line, idle high.
busy  output  1  high from the accept cycle until the packet is complete.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: serial_output=1, tx_ready=1, busy=0, byte index=0, bit counter=0, baud counter=0. Reset mid-packet aborts the packet immediately. serial_output is 1 in the cycle after the reset edge, and no partial byte is completed.
- Accept: a handshake occurs on a clk edge where tx_valid && tx_ready. The three fields are registered into a 36-bit holding register. tx_ready goes 0 and busy goes 1 from the next cycle.
- tx_valid while tx_ready=0 is ignored. There is no queueing, and fields are not resampled.
- Packet byte order:
  - B0 = HEADER_BYTE
  - B1 = {4'h0, shape_addr[11:8]}, B2 = shape_addr[7:0]
  - B3 = {4'h0, reg_addr[11:8]}, B4 = reg_addr[7:0]
  - B5 = {4'h0, data_in[11:8]}, B6 = data_in[7:0]
- Byte frame: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. serial_output is a registered output.
- Byte-level FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on load.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> IDLE after CLKS_PER_BIT cycles, raising a one-cycle done pulse.
- Packet sequencer states: P_IDLE, P_SEND, P_NEXT.
  - On accept, load B0.
  - On each done pulse, if index < 6 load the next byte in the same cycle. The next start bit begins directly after the previous stop bit, with no idle gap.
  - On done for B6, return to P_IDLE.
- Latency and timing, with the accept edge at cycle T:
  - serial_output falls to 0 at cycle T+1.
  - The packet occupies cycles T+1 .. T+70*CLKS_PER_BIT.
  - tx_ready=1 and busy=0 at cycle T+70*CLKS_PER_BIT+1.
  - Back-to-back accept is allowed in that cycle, so throughput is one packet per 70*CLKS_PER_BIT+1 cycles.
- Widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1, wrapping to 0 at each bit boundary.
  - Bit index is 3 bits; byte index is 3 bits (0..6).
  - Upper padding nibbles are always zero.
- Simultaneous events: reset has priority over accept and over every counter update.

Decomposition:
- Shared package (uart_pkg): CLKS_PER_BIT default, HEADER_BYTE, PACKET_BYTES=7, FIELD_W=12, and a byte-FSM state enum shared with the receiver.
- One sub-module: uart_tx_byte. It takes clk, rst_n, load, byte_in[7:0] and outputs serial_output, done, and byte_busy.
- readback_uart_tx holds the packet sequencer, the holding register and the handshake.

Test Plan:
- Reset idle: hold rst_n=0 for 5 cycles, then release -> serial_output=1, tx_ready=1, busy=0, and serial_output stays high with tx_valid=0 for 1000 cycles.
- Single packet, CLKS_PER_BIT=4: shape_addr=12'h123, reg_addr=12'h456, data_in=12'hABC accepted at T.
  - Decoded bytes are A5,01,23,04,56,0A,BC with correct start/stop bits; serial_output falls at T+1.
  - tx_ready returns high at T+281.
- Bit timing: CLKS_PER_BIT=4, single packet -> every bit is exactly 4 cycles, and there are no idle-high cycles between the stop bit of byte n and the start bit of byte n+1.
- Handshake: tx_valid held high with changing fields during a packet -> only one packet sent, carrying the fields sampled at accept.
  - A second record with tx_valid still high is accepted exactly at T+281 and starts at T+282.
- Boundaries, CLKS_PER_BIT=2: fields 12'hFFF,12'h000,12'h800 -> bytes A5,0F,FF,00,00,08,00.
  - Total packet length is 140 cycles.
- Reset mid-operation: assert rst_n=0 during byte B3 data bits -> serial_output=1 in the next cycle, tx_ready=1 after release.
  - A new record (12'h001,12'h002,12'h003) then sends a clean full packet A5,00,01,00,02,00,03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing, packet framing constants and FSM encodings
// used by the readback transmitter and the command receiver.
package uart_pkg;

  localparam int         CLKS_PER_BIT_DEF = 868;
  localparam logic [7:0] HEADER_BYTE_DEF  = 8'hA5;
  localparam int         PACKET_BYTES     = 7;
  localparam int         FIELD_W          = 12;
  localparam int         HOLD_W           = 3 * FIELD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // P_SEND: header or a middle byte is on the wire.
  // P_NEXT: the final byte is on the wire; its done pulse ends the packet.
  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_SEND = 2'd1,
    P_NEXT = 2'd2
  } pkt_state_e;

  // Payload bytes 1..6 of a packet; hold = {shape_addr, reg_addr, data_in}.
  function automatic logic [7:0] payload_byte(input logic [HOLD_W-1:0] hold,
                                              input logic [2:0]        idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd1:    b = {4'h0, hold[35:32]};
      3'd2:    b = hold[31:24];
      3'd3:    b = {4'h0, hold[23:20]};
      3'd4:    b = hold[19:12];
      3'd5:    b = {4'h0, hold[11:8]};
      3'd6:    b = hold[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 transmitter. A load in the cycle its stop bit finishes starts the
// next start bit with no idle gap, so bytes can be chained seamlessly.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       serial_output,
  output logic       done,
  output logic       byte_busy
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        baud_d   = '0;
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          baud_d   = '0;
          bit_d    = '0;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            // Shift so the next data bit is always at shift_q[0] on the following edge.
            bit_d    = bit_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Load wins over the STOP->IDLE step so chained bytes start straight away.
    if (load) begin
      state_d  = START;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = byte_in;
      serial_d = 1'b0;
    end
  end

  assign serial_output = serial_q;
  assign byte_busy     = (state_q != IDLE);

endmodule

// File: rtl/readback_uart_tx.sv
// Readback record transmitter: captures {shape, reg, data} on handshake and sends the
// fixed 7-byte packet (header then three zero-padded 12-bit fields, high part first).
module readback_uart_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [FIELD_W-1:0] shape_addr,
  input  logic [FIELD_W-1:0] reg_addr,
  input  logic [FIELD_W-1:0] data_in,
  output logic               serial_output,
  output logic               busy
);

  localparam logic [2:0] LAST_IDX = 3'(PACKET_BYTES - 1);

  pkt_state_e        pkt_q, pkt_d;
  logic [2:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        next_idx;
  logic              accept;
  logic              load;
  logic [7:0]        byte_sel;
  logic              done;
  logic              byte_busy;

  // Handshake: a record transfers on a rising edge where tx_valid && tx_ready. The fields
  // are captured only then; tx_valid seen while tx_ready is low has no effect.
  assign tx_ready = (pkt_q == P_IDLE) && !byte_busy;
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign next_idx = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q  <= P_IDLE;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    pkt_d    = pkt_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    load     = 1'b0;
    byte_sel = HEADER_BYTE;

    case (pkt_q)
      P_IDLE: begin
        // The header is constant, so it loads in the accept cycle itself.
        if (accept) begin
          hold_d   = {shape_addr, reg_addr, data_in};
          idx_d    = '0;
          load     = 1'b1;
          byte_sel = HEADER_BYTE;
          pkt_d    = P_SEND;
        end
      end
      P_SEND: begin
        if (done) begin
          idx_d    = next_idx;
          load     = 1'b1;
          byte_sel = payload_byte(hold_q, next_idx);
          if (next_idx == LAST_IDX) begin
            pkt_d = P_NEXT;
          end
        end
      end
      P_NEXT: begin
        if (done) begin
          idx_d = '0;
          pkt_d = P_IDLE;
        end
      end
      default: begin
        idx_d = '0;
        pkt_d = P_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .byte_in      (byte_sel),
    .serial_output(serial_output),
    .done         (done),
    .byte_busy    (byte_busy)
  );

endmodule
